// File: rtl/i2c_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_reg_pkg
// Purpose  : Shared constants for the I2C slave register bridge. Holds the
//            one-hot FSM state encoding, the default pointer width and the
//            byte width.
// Ports    : none (package)
// Options  : I2C_REG_AUTOINC_EN (consumed by i2c_slave_reg_bridge)
// Revision : 1.0 - initial release
// ============================================================================
package i2c_reg_pkg;

  localparam int STATE_W = 4;

  // One-hot FSM encoding
  localparam logic [STATE_W-1:0] ST_IDLE        = 4'b0001;
  localparam logic [STATE_W-1:0] ST_GET_POINTER = 4'b0010;
  localparam logic [STATE_W-1:0] ST_WRITE_REG   = 4'b0100;
  localparam logic [STATE_W-1:0] ST_READ_REG    = 4'b1000;

  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int BYTE_W             = 8;

endpackage : i2c_reg_pkg
`default_nettype wire

// File: rtl/i2c_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : i2c_reg_file
// Purpose  : 2**ADDR_WIDTH x 8 register array with one prioritised write port
//            (master over host), a combinational read port addressed by the
//            register pointer and a registered host read port.
// Ports    : clock, reset_n        - clock, async active-low reset
//            m_we/m_addr/m_wdata   - master (I2C) write, highest priority
//            h_we/h_addr/h_wdata   - host write; h_addr also drives host read
//            rd_addr -> rd_data    - combinational read (pointer side)
//            host_rdata            - registered read of h_addr
// Revision : 1.0 - initial release
// ============================================================================
module i2c_reg_file
  import i2c_reg_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  m_we,
  input  logic [ADDR_WIDTH-1:0] m_addr,
  input  logic [BYTE_W-1:0]     m_wdata,
  input  logic                  h_we,
  input  logic [ADDR_WIDTH-1:0] h_addr,
  input  logic [BYTE_W-1:0]     h_wdata,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [BYTE_W-1:0]     rd_data,
  output logic [BYTE_W-1:0]     host_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [BYTE_W-1:0] mem [DEPTH];

  // The master write is issued last so it overrides a host write to the
  // same index in the same cycle; different indices both land.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (h_we) begin
        mem[h_addr] <= h_wdata;
      end
      if (m_we) begin
        mem[m_addr] <= m_wdata;
      end
    end
  end

  assign rd_data = mem[rd_addr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      host_rdata <= '0;
    end else begin
      host_rdata <= mem[h_addr];
    end
  end

endmodule : i2c_reg_file
`default_nettype wire

// File: rtl/i2c_slave_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_reg_bridge
// Purpose  : Register-map back end for I2C_slave. First received byte of a
//            write transaction loads the register pointer; following bytes
//            are written at the pointer. Read transactions present
//            register[pointer] on data_write. A host port shares the array.
// Ports    : clock, reset_n              - clock, async active-low reset
//            rw_flag, transfer_status,
//            data_finish, data_read,
//            slave_error                 - byte-level status from I2C_slave
//            data_write                  - byte to transmit (registered)
//            host_we/addr/wdata/rdata    - local host access
//            reg_wr_pulse, reg_wr_index  - master write notification
//            host_collision              - host write dropped
//            pointer                     - current register pointer
// Options  : I2C_REG_AUTOINC_EN - when defined, the pointer auto-increments
//            after each written or read byte; otherwise it only changes
//            when a pointer byte is received.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_reg_bridge
  import i2c_reg_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  rw_flag,
  input  logic                  transfer_status,
  input  logic                  data_finish,
  input  logic [BYTE_W-1:0]     data_read,
  input  logic                  slave_error,
  output logic [BYTE_W-1:0]     data_write,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [BYTE_W-1:0]     host_wdata,
  output logic [BYTE_W-1:0]     host_rdata,
  output logic                  reg_wr_pulse,
  output logic [ADDR_WIDTH-1:0] reg_wr_index,
  output logic                  host_collision,
  output logic [ADDR_WIDTH-1:0] pointer
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;
  logic               ts_prev;
  logic               ts_rise;
  logic               byte_ok;
  logic               master_we;
  logic               ptr_load;
  logic               ptr_inc;
  logic               collision;
  logic [BYTE_W-1:0]  ptr_rdata;

  assign ts_rise = transfer_status & ~ts_prev;
  assign byte_ok = data_finish & ~slave_error;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. Loss of transfer_status (STOP or repeated START)
  // always returns to IDLE so the next transfer re-enters via an edge.
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    if (!transfer_status) begin
      next_state = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ts_rise) begin
            next_state = rw_flag ? ST_GET_POINTER : ST_READ_REG;
          end
        end
        ST_GET_POINTER: begin
          if (byte_ok) begin
            next_state = ST_WRITE_REG;
          end
        end
        ST_WRITE_REG: next_state = ST_WRITE_REG;
        ST_READ_REG:  next_state = ST_READ_REG;
        default:      next_state = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs (write enable and pointer control)
  // --------------------------------------------------------------------------
  always_comb begin
    master_we = 1'b0;
    ptr_load  = 1'b0;
    ptr_inc   = 1'b0;
    unique case (state)
      ST_GET_POINTER: ptr_load  = byte_ok;
      ST_WRITE_REG:   master_we = byte_ok;
      default: ;
    endcase
`ifdef I2C_REG_AUTOINC_EN
    // Reads advance on every completed byte; the slave's error flag only
    // guards bytes the master sends to us.
    ptr_inc = master_we | ((state == ST_READ_REG) & data_finish);
`else
    ptr_inc = 1'b0;
`endif
  end

  assign collision = host_we & master_we & (host_addr == pointer);

  // --------------------------------------------------------------------------
  // Pointer, notifications and transmit byte
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts_prev        <= 1'b0;
      pointer        <= '0;
      reg_wr_pulse   <= 1'b0;
      reg_wr_index   <= '0;
      host_collision <= 1'b0;
      data_write     <= '0;
    end else begin
      ts_prev        <= transfer_status;
      reg_wr_pulse   <= master_we;
      host_collision <= collision;
      // Registered copy of the pointer read port: one extra cycle after a
      // pointer change before the new byte appears here.
      data_write     <= ptr_rdata;
      if (master_we) begin
        reg_wr_index <= pointer;
      end
      if (ptr_load) begin
        pointer <= data_read[ADDR_WIDTH-1:0];
      end else if (ptr_inc) begin
        pointer <= pointer + ADDR_WIDTH'(1);
      end
    end
  end

  i2c_reg_file #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_reg_file (
    .clock      (clock),
    .reset_n    (reset_n),
    .m_we       (master_we),
    .m_addr     (pointer),
    .m_wdata    (data_read),
    .h_we       (host_we),
    .h_addr     (host_addr),
    .h_wdata    (host_wdata),
    .rd_addr    (pointer),
    .rd_data    (ptr_rdata),
    .host_rdata (host_rdata)
  );

endmodule : i2c_slave_reg_bridge
`default_nettype wire

// File: tb/tb_i2c_slave_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_reg_bridge
// Purpose  : Self-checking bench for i2c_slave_reg_bridge. A transaction-level
//            model (register array + pointer + transfer mode) predicts
//            results; expectations are queued and a monitor compares them
//            when the DUT presents write/collision pulses or sample strobes.
// Options  : follows I2C_REG_AUTOINC_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_reg_bridge;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef I2C_REG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  // sample kinds
  localparam int K_DW   = 0;
  localparam int K_PTR  = 1;
  localparam int K_HRD  = 2;
  localparam int K_ZERO = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          rw_flag = 1'b0;
  logic          transfer_status = 1'b0;
  logic          data_finish = 1'b0;
  logic [7:0]    data_read = '0;
  logic          slave_error = 1'b0;
  logic [7:0]    data_write;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [7:0]    host_wdata = '0;
  logic [7:0]    host_rdata;
  logic          reg_wr_pulse;
  logic [AW-1:0] reg_wr_index;
  logic          host_collision;
  logic [AW-1:0] pointer;

  always #5 clock = ~clock;

  i2c_slave_reg_bridge #(.ADDR_WIDTH(AW)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .rw_flag         (rw_flag),
    .transfer_status (transfer_status),
    .data_finish     (data_finish),
    .data_read       (data_read),
    .slave_error     (slave_error),
    .data_write      (data_write),
    .host_we         (host_we),
    .host_addr       (host_addr),
    .host_wdata      (host_wdata),
    .host_rdata      (host_rdata),
    .reg_wr_pulse    (reg_wr_pulse),
    .reg_wr_index    (reg_wr_index),
    .host_collision  (host_collision),
    .pointer         (pointer)
  );

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

  // ---------------- reference model ----------------
  logic [7:0] mem_m [DEPTH];
  int         ptr_m = 0;
  int         mode_m = 0;   // 0 idle, 1 pointer byte next, 2 writing, 3 reading

  typedef struct { int idx; int cyc; } wr_t;
  typedef struct { int kind; int val; } samp_t;
  wr_t   wr_q[$];
  int    col_q[$];
  samp_t samp_q[$];
  logic  samp = 1'b0;

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    wr_t   we;
    samp_t se;
    int    cc;
    int    got;
    if (reset_n && reg_wr_pulse) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_pulse: unexpected pulse index %0d at cycle %0d, none required", reg_wr_index, cyc_cnt);
      end else begin
        we = wr_q.pop_front();
        if (int'(reg_wr_index) != we.idx || cyc_cnt != we.cyc) begin
          errors++;
          $display("FAIL wr_pulse: got index %0d cycle %0d, required index %0d cycle %0d",
                   reg_wr_index, cyc_cnt, we.idx, we.cyc);
        end
      end
    end
    if (reset_n && host_collision) begin
      checks++;
      if (col_q.size() == 0) begin
        errors++;
        $display("FAIL collision: unexpected pulse at cycle %0d, none required", cyc_cnt);
      end else begin
        cc = col_q.pop_front();
        if (cyc_cnt != cc) begin
          errors++;
          $display("FAIL collision: got pulse at cycle %0d, required cycle %0d", cyc_cnt, cc);
        end
      end
    end
    if (samp && samp_q.size() != 0) begin
      se = samp_q.pop_front();
      checks++;
      case (se.kind)
        K_DW:    got = int'(data_write);
        K_PTR:   got = int'(pointer);
        K_HRD:   got = int'(host_rdata);
        default: got = (data_write != 0 || host_rdata != 0 || reg_wr_pulse || reg_wr_index != 0 ||
                        host_collision || pointer != 0) ? 1 : 0;
      endcase
      if (got != se.val) begin
        errors++;
        $display("FAIL sample kind %0d: got %0h, required %0h (cycle %0d)", se.kind, got, se.val, cyc_cnt);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic sample(input int kind, input int val);
    samp_t s;
    s.kind = kind;
    s.val  = val;
    samp_q.push_back(s);
    samp = 1'b1;
    tick();
    samp = 1'b0;
  endtask

  task automatic model_reset();
    foreach (mem_m[i]) mem_m[i] = 8'h00;
    ptr_m  = 0;
    mode_m = 0;
  endtask

  task automatic start_txn(input bit rw);
    transfer_status = 1'b1;
    rw_flag         = rw;
    tick(2);
    mode_m = rw ? 1 : 3;
  endtask

  task automatic stop_txn();
    transfer_status = 1'b0;
    mode_m          = 0;
    tick(2);
  endtask

  // One completed byte from the slave, optionally with a host write in the
  // same cycle.
  task automatic byte_pulse(input int b, input bit err, input bit hw, input int ha, input int hd);
    bit  m_wr;
    wr_t w;
    data_read   = 8'(b);
    slave_error = err;
    data_finish = 1'b1;
    host_we     = hw;
    host_addr   = AW'(ha);
    host_wdata  = 8'(hd);
    m_wr = (mode_m == 2) && !err;
    if (mode_m == 1 && !err) begin
      ptr_m  = b % DEPTH;
      mode_m = 2;
    end
    if (hw) begin
      if (m_wr && ha == ptr_m) col_q.push_back(cyc_cnt + 1);
      else mem_m[ha] = 8'(hd);
    end
    if (m_wr) begin
      w.idx = ptr_m;
      w.cyc = cyc_cnt + 1;
      wr_q.push_back(w);
      mem_m[ptr_m] = 8'(b);
      if (AUTOINC) ptr_m = (ptr_m + 1) % DEPTH;
    end else if (mode_m == 3 && AUTOINC) begin
      ptr_m = (ptr_m + 1) % DEPTH;
    end
    tick();
    data_finish = 1'b0;
    slave_error = 1'b0;
    host_we     = 1'b0;
    tick(3);
  endtask

  task automatic wr_byte(input int b);
    byte_pulse(b, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic rd_byte();
    sample(K_DW, int'(mem_m[ptr_m]));
    byte_pulse(int'($urandom_range(0, 255)), 1'b0, 1'b0, 0, 0);
  endtask

  task automatic host_write(input int a, input int d);
    host_we    = 1'b1;
    host_addr  = AW'(a);
    host_wdata = 8'(d);
    mem_m[a]   = 8'(d);
    tick();
    host_we = 1'b0;
    tick(2);
  endtask

  task automatic host_read(input int a);
    host_addr = AW'(a);
    tick();
    sample(K_HRD, int'(mem_m[a]));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    model_reset();
    tick(3);
    sample(K_ZERO, 0);
    reset_n = 1'b1;
    tick(2);
    sample(K_PTR, 0);

    // write 0x03, 0xA5, 0x5A
    start_txn(1'b1);
    wr_byte(8'h03); wr_byte(8'hA5); wr_byte(8'h5A);
    stop_txn();
    sample(K_PTR, ptr_m);
    host_read(3); host_read(4);

    // pointer write, repeated START, read three bytes
    host_write(2, 8'h11); host_write(3, 8'h22); host_write(4, 8'h33);
    start_txn(1'b1);
    wr_byte(8'h02);
    stop_txn();
    start_txn(1'b0);
    rd_byte(); rd_byte(); rd_byte();
    stop_txn();
    sample(K_PTR, ptr_m);

    // wrap-around and upper pointer bits ignored
    start_txn(1'b1);
    wr_byte(8'h0F); wr_byte(8'hAA); wr_byte(8'hBB);
    stop_txn();
    host_read(15); host_read(0);
    start_txn(1'b1);
    wr_byte(8'hF7);
    stop_txn();
    sample(K_PTR, ptr_m);

    // host/master same-index collision, then different-index host write
    start_txn(1'b1);
    wr_byte(8'h06);
    byte_pulse(8'h44, 1'b0, 1'b1, 6, 8'h99);
    byte_pulse(8'h55, 1'b0, 1'b1, 1, 8'h12);
    stop_txn();
    host_read(6); host_read(1);

    // slave error during a data byte
    start_txn(1'b1);
    wr_byte(8'h08);
    byte_pulse(8'h77, 1'b1, 1'b0, 0, 0);
    sample(K_PTR, ptr_m);
    stop_txn();
    host_read(8);

    // data_finish while idle is ignored
    byte_pulse(8'h3C, 1'b0, 1'b0, 0, 0);
    sample(K_PTR, ptr_m);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          start_txn(1'b1);
          byte_pulse(int'($urandom_range(0, 255)), ($urandom_range(0, 9) == 0), 1'b0, 0, 0);
          n = int'($urandom_range(1, 4));
          for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 3) == 0)
              byte_pulse(int'($urandom_range(0, 255)), ($urandom_range(0, 9) == 0), 1'b1,
                         ($urandom_range(0, 1) == 0) ? ptr_m : int'($urandom_range(0, DEPTH - 1)),
                         int'($urandom_range(0, 255)));
            else
              byte_pulse(int'($urandom_range(0, 255)), ($urandom_range(0, 9) == 0), 1'b0, 0, 0);
          end
          stop_txn();
          sample(K_PTR, ptr_m);
        end
        1: begin
          start_txn(1'b0);
          n = int'($urandom_range(1, 4));
          for (int k = 0; k < n; k++) rd_byte();
          stop_txn();
        end
        2: host_write(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 255)));
        default: host_read(int'($urandom_range(0, DEPTH - 1)));
      endcase
    end

    // reset in the middle of a write byte: no partial write
    start_txn(1'b1);
    wr_byte(8'h05);
    wr_byte(8'hC3);
    data_read   = 8'h66;
    data_finish = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    begin
      samp_t s;
      s.kind = K_ZERO;
      s.val  = 0;
      samp_q.push_back(s);
    end
    samp = 1'b1;
    @(negedge clock);
    #1;
    samp = 1'b0;
    data_finish     = 1'b0;
    transfer_status = 1'b0;
    model_reset();
    tick(2);
    reset_n = 1'b1;
    tick(2);
    sample(K_PTR, 0);
    for (int a = 0; a < DEPTH; a++) host_read(a);
    tick(4);

    checks++;
    if (wr_q.size() != 0 || col_q.size() != 0 || samp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending wr %0d col %0d samp %0d, required 0 0 0",
               wr_q.size(), col_q.size(), samp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_i2c_slave_reg_bridge
`default_nettype wire
